// File: rtl/bc_msg_arbiter.sv
// Broadcast-message arbiter: buffers one message per core, grants round-robin and
// serialises the winners onto a single registered broadcast bus with traffic counters.
module bc_msg_arbiter #(
  parameter int unsigned CORE_COUNT     = 16,
  parameter int unsigned CORE_ID_WIDTH  = $clog2(CORE_COUNT),
  parameter int unsigned BC_REGION_SIZE = 4048,
  parameter int unsigned MSG_WIDTH      = 32 + 4 + $clog2(BC_REGION_SIZE) - 2
) (
  input  logic                            sys_clk,
  input  logic                            sys_rst,
  input  logic [CORE_COUNT*MSG_WIDTH-1:0] core_msg,
  input  logic [CORE_COUNT-1:0]           core_msg_valid,
  output logic [CORE_COUNT-1:0]           core_msg_ready,
  output logic [MSG_WIDTH-1:0]            bc_msg,
  output logic                            bc_msg_valid,
  output logic [CORE_ID_WIDTH-1:0]        bc_msg_src,
  output logic [31:0]                     msg_count,
  output logic [15:0]                     drop_count
);

  logic [MSG_WIDTH-1:0]     r_slot [CORE_COUNT];
  logic [CORE_COUNT-1:0]    r_full;
  logic [CORE_ID_WIDTH-1:0] r_rr_ptr;
  logic [MSG_WIDTH-1:0]     r_bc_msg;
  logic                     r_bc_valid;
  logic [CORE_ID_WIDTH-1:0] r_bc_src;
  logic [31:0]              r_msg_count;
  logic [15:0]              r_drop_count;

  logic [CORE_COUNT-1:0]    w_grant;
  logic                     w_grant_vld;
  logic [CORE_ID_WIDTH-1:0] w_grant_idx;
  logic [CORE_ID_WIDTH:0]   w_idx;
  logic [CORE_ID_WIDTH-1:0] w_ptr_nxt;
  logic [CORE_COUNT-1:0]    w_ready;
  logic [CORE_COUNT-1:0]    w_cap;
  logic [CORE_COUNT-1:0]    w_null;
  logic [CORE_COUNT-1:0]    w_load;
  logic [31:0]              w_drop_sum;
  logic [15:0]              w_drop_nxt;

  // First full slot at or above the pointer, wrapping at CORE_COUNT.
  always_comb begin
    w_grant     = '0;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_idx       = '0;
    for (int k = 0; k < int'(CORE_COUNT); k++) begin
      w_idx = {1'b0, r_rr_ptr} + (CORE_ID_WIDTH+1)'(k);
      if (w_idx >= (CORE_ID_WIDTH+1)'(CORE_COUNT)) begin
        w_idx = w_idx - (CORE_ID_WIDTH+1)'(CORE_COUNT);
      end
      if (!w_grant_vld && r_full[w_idx[CORE_ID_WIDTH-1:0]]) begin
        w_grant_vld                      = 1'b1;
        w_grant_idx                      = w_idx[CORE_ID_WIDTH-1:0];
        w_grant[w_idx[CORE_ID_WIDTH-1:0]] = 1'b1;
      end
    end
  end

  always_comb begin
    if (w_grant_idx == CORE_ID_WIDTH'(CORE_COUNT - 1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = w_grant_idx + CORE_ID_WIDTH'(1);
    end
  end

  // A granted slot may be refilled in the same cycle, so ready ignores valid.
  assign w_ready = sys_rst ? '0 : (~r_full | w_grant);
  assign w_cap   = core_msg_valid & w_ready;

  always_comb begin
    w_null = '0;
    w_load = '0;
    for (int i = 0; i < int'(CORE_COUNT); i++) begin
      if (w_cap[i]) begin
        if (core_msg[i*MSG_WIDTH+32 +: 4] == 4'h0) begin
          w_null[i] = 1'b1;
        end else begin
          w_load[i] = 1'b1;
        end
      end
    end
  end

  // Several cores may drop in one cycle; sum them before saturating.
  always_comb begin
    w_drop_sum = {16'd0, r_drop_count};
    for (int i = 0; i < int'(CORE_COUNT); i++) begin
      w_drop_sum = w_drop_sum + 32'(w_null[i]);
    end
    w_drop_nxt = (w_drop_sum > 32'h0000_FFFF) ? 16'hFFFF : w_drop_sum[15:0];
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_full       <= '0;
      r_rr_ptr     <= '0;
      r_bc_msg     <= '0;
      r_bc_valid   <= 1'b0;
      r_bc_src     <= '0;
      r_msg_count  <= '0;
      r_drop_count <= '0;
    end else begin
      r_full       <= (r_full & ~w_grant) | w_load;
      r_bc_valid   <= w_grant_vld;
      r_drop_count <= w_drop_nxt;
      if (w_grant_vld) begin
        r_rr_ptr    <= w_ptr_nxt;
        r_bc_msg    <= r_slot[w_grant_idx];
        r_bc_src    <= w_grant_idx;
        r_msg_count <= r_msg_count + 32'd1;
      end
    end
  end

  // Slot payloads are qualified by r_full and need no reset.
  always_ff @(posedge sys_clk) begin
    for (int i = 0; i < int'(CORE_COUNT); i++) begin
      if (w_load[i]) begin
        r_slot[i] <= core_msg[i*MSG_WIDTH +: MSG_WIDTH];
      end
    end
  end

  assign core_msg_ready = w_ready;
  assign bc_msg         = r_bc_msg;
  assign bc_msg_valid   = r_bc_valid;
  assign bc_msg_src     = r_bc_src;
  assign msg_count      = r_msg_count;
  assign drop_count     = r_drop_count;

endmodule

// File: tb/tb_bc_msg_arbiter.sv
// Directed self-checking bench for bc_msg_arbiter with hand-computed expectations.
module tb_bc_msg_arbiter;

  localparam int CC = 16;
  localparam int MW = 46;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic [CC*MW-1:0]  core_msg = '0;
  logic [CC-1:0]     core_msg_valid = '0;
  logic [CC-1:0]     core_msg_ready;
  logic [MW-1:0]     bc_msg;
  logic              bc_msg_valid;
  logic [3:0]        bc_msg_src;
  logic [31:0]       msg_count;
  logic [15:0]       drop_count;

  int checks = 0;
  int errors = 0;

  bc_msg_arbiter dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .core_msg       (core_msg),
    .core_msg_valid (core_msg_valid),
    .core_msg_ready (core_msg_ready),
    .bc_msg         (bc_msg),
    .bc_msg_valid   (bc_msg_valid),
    .bc_msg_src     (bc_msg_src),
    .msg_count      (msg_count),
    .drop_count     (drop_count)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [MW-1:0] mk(input logic [31:0] d, input logic [3:0] s,
                                       input logic [9:0] a);
    return {a, s, d};
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_core(input int i, input logic [MW-1:0] m);
    core_msg[i*MW +: MW] = m;
  endtask

  task automatic do_reset();
    core_msg_valid = '0;
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < CC; i++) set_core(i, mk(32'h100 + i, 4'hF, 10'(i)));
    core_msg_valid = '1;
    sys_rst = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (core_msg_ready !== 16'h0000) begin
        errors++;
        $display("FAIL reset_ready cyc%0d got %h want 0000", c, core_msg_ready);
      end
      tick();
    end
    sys_rst = 1'b0;
    #1;
    checks++;
    if (core_msg_ready !== 16'hFFFF) begin
      errors++; $display("FAIL post_reset_ready got %h want ffff", core_msg_ready);
    end
    checks++;
    if (bc_msg_valid !== 1'b0 || bc_msg !== '0 || bc_msg_src !== 4'd0) begin
      errors++;
      $display("FAIL post_reset_out got v=%b m=%h s=%0d want 0", bc_msg_valid, bc_msg, bc_msg_src);
    end
    checks++;
    if (msg_count !== 32'd0 || drop_count !== 16'd0) begin
      errors++; $display("FAIL post_reset_cnt got %0d/%0d want 0/0", msg_count, drop_count);
    end
    core_msg_valid = '0;
    tick();
    checks++;
    if (bc_msg_valid !== 1'b0 || core_msg_ready !== 16'hFFFF) begin
      errors++;
      $display("FAIL reset_no_capture got v=%b rdy=%h want 0/ffff", bc_msg_valid, core_msg_ready);
    end
  endtask

  task automatic test_single();
    logic [MW-1:0] m;
    do_reset();
    m = mk(32'hDEADBEEF, 4'hF, 10'h010);
    set_core(3, m);
    core_msg_valid[3] = 1'b1;
    tick();
    core_msg_valid = '0;
    checks++;
    if (bc_msg_valid !== 1'b0) begin
      errors++; $display("FAIL single_t1 got v=%b want 0", bc_msg_valid);
    end
    tick();
    checks++;
    if (bc_msg_valid !== 1'b1 || bc_msg !== m || bc_msg_src !== 4'd3 || msg_count !== 32'd1) begin
      errors++;
      $display("FAIL single_t2 got v=%b m=%h s=%0d c=%0d want 1 %h 3 1",
               bc_msg_valid, bc_msg, bc_msg_src, msg_count, m);
    end
    tick();
    checks++;
    if (bc_msg_valid !== 1'b0 || bc_msg !== m) begin
      errors++; $display("FAIL single_t3 got v=%b m=%h want 0 hold %h", bc_msg_valid, bc_msg, m);
    end
  endtask

  task automatic test_simultaneous();
    int src_exp [3] = '{0, 5, 15};
    do_reset();
    for (int j = 0; j < 3; j++) begin
      set_core(src_exp[j], mk(32'hA0 + src_exp[j], 4'hF, 10'h3));
      core_msg_valid[src_exp[j]] = 1'b1;
    end
    tick();
    core_msg_valid = '0;
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++;
      if (bc_msg_valid !== 1'b1 || bc_msg_src !== 4'(src_exp[j]) ||
          bc_msg[31:0] !== 32'hA0 + src_exp[j]) begin
        errors++;
        $display("FAIL simul_%0d got v=%b s=%0d d=%h want 1 %0d %h", j, bc_msg_valid,
                 bc_msg_src, bc_msg[31:0], src_exp[j], 32'hA0 + src_exp[j]);
      end
    end
    tick();
    checks++;
    if (bc_msg_valid !== 1'b0) begin
      errors++; $display("FAIL simul_idle got v=%b want 0", bc_msg_valid);
    end
    // Pointer back at 0: core 1 must beat core 15.
    set_core(1, mk(32'hB1, 4'hF, 10'h0));
    set_core(15, mk(32'hBF, 4'hF, 10'h0));
    core_msg_valid[1] = 1'b1;
    core_msg_valid[15] = 1'b1;
    tick();
    core_msg_valid = '0;
    tick();
    checks++;
    if (bc_msg_valid !== 1'b1 || bc_msg_src !== 4'd1) begin
      errors++; $display("FAIL rr_wrap_a got v=%b s=%0d want 1 1", bc_msg_valid, bc_msg_src);
    end
    tick();
    checks++;
    if (bc_msg_valid !== 1'b1 || bc_msg_src !== 4'd15 || msg_count !== 32'd5) begin
      errors++;
      $display("FAIL rr_wrap_b got v=%b s=%0d c=%0d want 1 15 5", bc_msg_valid, bc_msg_src, msg_count);
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      set_core(7, mk(32'h700 + k, 4'hF, 10'(k)));
      core_msg_valid[7] = 1'b1;
      #1;
      checks++;
      if (core_msg_ready[7] !== 1'b1) begin
        errors++; $display("FAIL stream_ready k%0d got %b want 1", k, core_msg_ready[7]);
      end
      tick();
      if (k >= 1) begin
        checks++;
        if (bc_msg_valid !== 1'b1 || bc_msg[31:0] !== 32'h700 + k - 1 || bc_msg_src !== 4'd7) begin
          errors++;
          $display("FAIL stream_out k%0d got v=%b d=%h s=%0d want 1 %h 7", k, bc_msg_valid,
                   bc_msg[31:0], bc_msg_src, 32'h700 + k - 1);
        end
      end
    end
    core_msg_valid = '0;
    tick();
    checks++;
    if (bc_msg_valid !== 1'b1 || bc_msg[31:0] !== 32'h707 || msg_count !== 32'd8) begin
      errors++;
      $display("FAIL stream_last got v=%b d=%h c=%0d want 1 707 8", bc_msg_valid, bc_msg[31:0], msg_count);
    end
    tick();
    checks++;
    if (bc_msg_valid !== 1'b0) begin
      errors++; $display("FAIL stream_end got v=%b want 0", bc_msg_valid);
    end
  endtask

  task automatic test_all_cores();
    int cnt [CC];
    do_reset();
    for (int i = 0; i < CC; i++) begin
      set_core(i, mk(32'hC000 + i, 4'hF, 10'(i)));
      cnt[i] = 0;
    end
    core_msg_valid = '1;
    tick();
    for (int k = 0; k < 32; k++) begin
      tick();
      checks++;
      if (bc_msg_valid !== 1'b1 || bc_msg_src !== 4'(k % CC) ||
          bc_msg[31:0] !== 32'hC000 + (k % CC)) begin
        errors++;
        $display("FAIL fair_seq k%0d got v=%b s=%0d d=%h want 1 %0d", k, bc_msg_valid,
                 bc_msg_src, bc_msg[31:0], k % CC);
      end
      if (bc_msg_valid === 1'b1) cnt[bc_msg_src]++;
    end
    for (int i = 0; i < CC; i++) begin
      checks++;
      if (cnt[i] != 2) begin
        errors++; $display("FAIL fair_count src%0d got %0d want 2", i, cnt[i]);
      end
    end
    checks++;
    if (msg_count !== 32'd32) begin
      errors++; $display("FAIL fair_msg_count got %0d want 32", msg_count);
    end
    core_msg_valid = '0;
    repeat (18) tick();
  endtask

  task automatic test_null();
    do_reset();
    set_core(2, mk(32'h1234, 4'h0, 10'h5));
    core_msg_valid[2] = 1'b1;
    tick();
    core_msg_valid = '0;
    checks++;
    if (drop_count !== 16'd1) begin
      errors++; $display("FAIL null_drop got %0d want 1", drop_count);
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bc_msg_valid !== 1'b0 || msg_count !== 32'd0) begin
        errors++;
        $display("FAIL null_nobc cyc%0d got v=%b c=%0d want 0 0", c, bc_msg_valid, msg_count);
      end
      tick();
    end
  endtask

  task automatic test_drop_sat();
    do_reset();
    for (int i = 0; i < CC; i++) set_core(i, mk(32'h0, 4'h0, 10'h0));
    core_msg_valid = '1;
    repeat (4095) tick();  // 4095 * 16 = 65520 drops
    core_msg_valid = 16'h3FFF;
    tick();
    core_msg_valid = '0;
    checks++;
    if (drop_count !== 16'hFFFE) begin
      errors++; $display("FAIL drop_preset got %h want fffe", drop_count);
    end
    core_msg_valid[2] = 1'b1;
    tick();
    checks++;
    if (drop_count !== 16'hFFFF) begin
      errors++; $display("FAIL drop_sat1 got %h want ffff", drop_count);
    end
    tick();
    tick();
    core_msg_valid = '0;
    checks++;
    if (drop_count !== 16'hFFFF || msg_count !== 32'd0 || bc_msg_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_sat3 got d=%h c=%0d v=%b want ffff 0 0", drop_count, msg_count, bc_msg_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_core(1, mk(32'h11, 4'hF, 10'h1));
    set_core(4, mk(32'h44, 4'hF, 10'h4));
    core_msg_valid[1] = 1'b1;
    core_msg_valid[4] = 1'b1;
    tick();
    core_msg_valid = '0;
    tick();
    checks++;
    if (bc_msg_valid !== 1'b1 || bc_msg_src !== 4'd1 || msg_count !== 32'd1) begin
      errors++;
      $display("FAIL mid_pre got v=%b s=%0d c=%0d want 1 1 1", bc_msg_valid, bc_msg_src, msg_count);
    end
    sys_rst = 1'b1;
    #1;
    checks++;
    if (core_msg_ready !== 16'h0000) begin
      errors++; $display("FAIL mid_rst_ready got %h want 0000", core_msg_ready);
    end
    tick();
    sys_rst = 1'b0;
    #1;
    checks++;
    if (msg_count !== 32'd0 || core_msg_ready !== 16'hFFFF) begin
      errors++; $display("FAIL mid_post got c=%0d rdy=%h want 0 ffff", msg_count, core_msg_ready);
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (bc_msg_valid !== 1'b0) begin
        errors++; $display("FAIL mid_novalid cyc%0d got %b want 0", c, bc_msg_valid);
      end
      tick();
    end
    checks++;
    if (msg_count !== 32'd0) begin
      errors++; $display("FAIL mid_count got %0d want 0", msg_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_stream();
    test_all_cores();
    test_null();
    test_drop_sat();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bc_msg_arbiter.md
# bc_msg_arbiter

Collects broadcast-message writes from every RISC-V core block's `bc_msg_out` port and serialises them onto the single `bc_msg_in` bus that fans back to all core blocks. Each message carries:
- a 32-bit data word,
- a 4-bit byte strobe,
- a word address in the broadcast region.

The block buffers one message per core, arbitrates round-robin, filters null writes and maintains traffic counters. It sits between the core array and the core array's broadcast inputs, with one instance per cluster.

## Interface
Parameters:
- `CORE_COUNT`, 16, number of attached core blocks.
- `CORE_ID_WIDTH`, `$clog2(CORE_COUNT)`, width of the source-ID field.
- `BC_REGION_SIZE`, 4048, broadcast region size in bytes.
- `MSG_WIDTH`, `32+4+$clog2(BC_REGION_SIZE)-2`, message width:
  - [31:0] data,
  - [35:32] strobe,
  - [MSG_WIDTH-1:36] word address.

Ports:
- `sys_clk`  in  1  clock. One clock domain only.
- `sys_rst`  in  1  synchronous, active-high reset.
- `core_msg`  in  CORE_COUNT*MSG_WIDTH  per-core message; core i occupies slice [i*MSG_WIDTH +: MSG_WIDTH].
- `core_msg_valid`  in  CORE_COUNT  per-core valid.
- `core_msg_ready`  out  CORE_COUNT  per-core ready.
- `bc_msg`  out  MSG_WIDTH  broadcast message to all cores.
- `bc_msg_valid`  out  1  broadcast strobe. There is no ready: consumers always accept.
- `bc_msg_src`  out  CORE_ID_WIDTH  index of the originating core.
- `msg_count`  out  32  broadcasts issued; wraps.
- `drop_count`  out  16  null messages discarded; saturates.

## Operation
Per-core slot:
- Each core has a one-entry holding register `slot[i]` with a `full[i]` flag.
- `core_msg_ready[i] = !sys_rst && (!full[i] || grant[i])`.
- Ready depends only on state and the grant, never on `core_msg_valid`.
- Capture occurs when `core_msg_valid[i] && core_msg_ready[i]`:
  - If the strobe is 4'h0, the message is consumed and not stored. `drop_count` increments, saturating at 16'hFFFF.
  - Otherwise, slot[i] is loaded and full[i] is set.
- Refill in the same cycle as the grant is allowed. A lone core can therefore stream at one message per cycle.

Arbiter:
- Pointer `rr_ptr` ranges 0..CORE_COUNT-1.
- Each cycle, `grant` is one-hot on the first full slot found searching upward from `rr_ptr`, wrapping from CORE_COUNT-1 to 0.
- If no slot is full, there is no grant.
- On a grant to core g:
  - full[g] clears, unless it is refilled in the same cycle.
  - `rr_ptr` becomes (g+1) mod CORE_COUNT.
  - The output register loads slot[g] and g.
- Simultaneous capture into a slot not being granted takes effect for the next cycle's arbitration.

Output register:
- `bc_msg_valid` is high for exactly one cycle per grant.
- `bc_msg` and `bc_msg_src` hold their last value when valid is low.
- `msg_count` increments by 1 in the same cycle `bc_msg_valid` is asserted (registered together); it wraps.

Fairness:
- With all cores continuously valid, each core receives exactly one grant per CORE_COUNT consecutive grants.
- Maximum wait from slot-full to grant is CORE_COUNT-1 cycles.

## Timing
- Latency: handshake in cycle t, slot full in t+1, grant in t+1, `bc_msg_valid` in t+2.
- Throughput: one broadcast per cycle while any slot is full.
- Reset (sync, active-high), applied on the clock edge where sys_rst is sampled high:
  - all full[] = 0, `rr_ptr` = 0;
  - `bc_msg` = 0, `bc_msg_src` = 0, `bc_msg_valid` = 0;
  - `msg_count` = 0, `drop_count` = 0.
- `core_msg_ready` = 0 throughout every cycle `sys_rst` is high.
- Reset mid-operation: pending slots are discarded without broadcast. An in-flight output register cleared by reset produces no `bc_msg_valid` in the following cycle.
- First capture is possible in the first cycle after `sys_rst` deasserts.
- All outputs are registered, except `core_msg_ready`, which is combinational from state and grant.

## Test plan
- Reset: hold `sys_rst` 3 cycles with all valids high. Required:
  - ready = 0 and no captures during reset;
  - after release, all outputs zero and ready = all ones.
- Single message: core 3 sends data 32'hDEADBEEF, strb 4'hF, addr 10'h010 in cycle t. Required:
  - t+2: `bc_msg_valid` = 1, identical `bc_msg`, `bc_msg_src` = 3, `msg_count` = 1;
  - t+3: `bc_msg_valid` = 0.
- Simultaneous: cores 0, 5 and 15 are valid in cycle t after reset (`rr_ptr` = 0). Required:
  - broadcasts from sources 0, 5, 15 in cycles t+2, t+3, t+4;
  - `rr_ptr` = 0 afterwards, i.e. wrapped past 15.
- Streaming and fairness:
  - Core 7 alone, valid continuously for 8 messages: 8 consecutive `bc_msg_valid` cycles with data in order.
  - All 16 cores continuously valid: over 32 broadcasts each source appears exactly twice, with no gap cycles.
- Null writes: core 2 sends strb 4'h0. Required:
  - no broadcast and `drop_count` = 1;
  - with `drop_count` preset to 16'hFFFE, three null messages leave it at 16'hFFFF.
- Reset mid-operation: slots 1 and 4 are full and a broadcast is in flight when `sys_rst` asserts for 1 cycle. Required:
  - no `bc_msg_valid` afterwards;
  - `msg_count` = 0 and all ready high after release.
